// File: rtl/drum_dot_accum.sv
// Saturating dot-product accumulator behind a DRUMs multiplier.
// It sums len signed products, then holds the result until the consumer takes it.
module drum_dot_accum #(
  parameter int N     = 16,
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_sat,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MAX_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   remaining;
  logic               sat;
  logic signed [ACC_W:0] sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               sum_ovf;
  logic               start_ok;

  // One guard bit above the accumulator exposes signed overflow of the add.
  always_comb begin
    sum_wide = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'($signed(in_prod));
    sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (!sum_ovf)
      sum_sat = sum_wide[ACC_W-1:0];
    else if (sum_wide[ACC_W])
      sum_sat = MAX_NEG;
    else
      sum_sat = MAX_POS;
  end

  assign start_ok = start && ((state == IDLE) || ((state == DONE) && out_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      sat       <= 1'b0;
    end else if (start_ok) begin
      acc       <= '0;
      sat       <= 1'b0;
      remaining <= len;
      state     <= (len == '0) ? DONE : ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc       <= sum_sat;
            remaining <= remaining - LEN_W'(1);
            if (sum_ovf)
              sat <= 1'b1;
            if (remaining == LEN_W'(1))
              state <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_acc   = acc;
  assign out_sat   = sat;

endmodule

// File: doc/drum_dot_accum.md
DRUM_DOT_ACCUM -- requirements
Module: drum_dot_accum

Interface
REQ-001 SHALL have parameter N, default 16: operand width of the upstream DRUMs multiplier; products are 2*N bits.
REQ-002 SHALL have parameter ACC_W, default 40: accumulator width, ACC_W >= 2*N.
REQ-003 SHALL have parameter LEN_W, default 8: width of the vector-length field.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1: begin a new dot-product operation.
REQ-007 SHALL have port len, input, LEN_W: number of products to accumulate; sampled when start is accepted.
REQ-008 SHALL have port in_valid, input, 1: in_prod is valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts in_prod this cycle.
REQ-010 SHALL have port in_prod, input, 2*N: signed two's-complement product from DRUMs output r.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-013 SHALL have port out_acc, output, ACC_W: signed accumulated sum.
REQ-014 SHALL have port out_sat, output, 1: saturation occurred during this operation.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-017 In IDLE, start=1 SHALL clear the accumulator, clear the saturation flag, load the remaining count from len, and move to ACCUM when len != 0, or to DONE with out_acc=0 when len == 0.
REQ-018 in_ready SHALL equal 1 only in ACCUM, derived from state only, with no combinational path from in_valid.
REQ-019 A product SHALL be accepted on a cycle when in_valid and in_ready are both 1; an accepted product SHALL add sign-extended in_prod to the accumulator and decrement the remaining count.
REQ-020 When the accepted product is the last one (remaining count == 1), the next state SHALL be DONE, and out_acc SHALL include that product in the first DONE cycle.
REQ-021 Accumulation SHALL saturate to +(2^(ACC_W-1) - 1) or -2^(ACC_W-1); any saturating add SHALL set out_sat, which stays set until the next accepted start.
REQ-022 Once saturated, further adds SHALL use the saturated value as the running sum; the sum may move back toward zero.
REQ-023 out_valid SHALL be 1 exactly in DONE; out_acc and out_sat SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 In DONE with out_ready=1 and start=0, the next state SHALL be IDLE.
REQ-025 In DONE with out_ready=1 and start=1 in the same cycle, the result SHALL be consumed and the new operation SHALL begin as in REQ-017, giving back-to-back operation with no IDLE cycle.
REQ-026 start SHALL be ignored in ACCUM, and in DONE when out_ready=0; len SHALL also be ignored in those cases.
REQ-027 Cycles with in_valid=0 in ACCUM SHALL hold all state (stall).
REQ-028 Latency SHALL be one cycle from the last accepted product to out_valid=1.
REQ-029 Throughput SHALL be one product per cycle.

Reset
REQ-030 With rst_n=0 at a clock edge, the block SHALL enter IDLE with accumulator 0, remaining count 0, in_ready=0, out_valid=0, out_acc=0, out_sat=0 and busy=0.
REQ-031 Reset SHALL override start and all handshakes; a reset taken mid-operation in ACCUM or DONE SHALL discard the partial result, and no out_valid SHALL follow.

Verification
REQ-032 Basic: start with len=3, then products 100, -40, 7 on consecutive cycles -> out_valid exactly 1 cycle after the third product, out_acc=67, out_sat=0.
REQ-033 Stall/backpressure: len=2, in_valid gapped 3 cycles between the products 5 and 6, out_ready held 0 for 4 cycles -> out_acc=11 held stable and out_valid held high throughout; busy=1 until out_ready=1.
REQ-034 Zero length: start with len=0 -> next cycle out_valid=1, out_acc=0, in_ready never 1.
REQ-035 Saturation: ACC_W=2*N=32, len=2, products 0x7FFFFFFF then 0x00000001 -> out_acc=0x7FFFFFFF, out_sat=1; the next operation with len=1 and product 2 -> out_acc=2, out_sat=0.
REQ-036 Back-to-back: out_ready=1 and start=1 with len=1 in the same DONE cycle -> first result consumed, in_ready=1 on the next cycle, and the second result equals only the new product.
REQ-037 Reset mid-run: rst_n=0 after 2 of 5 products -> all outputs 0 on the next cycle, no out_valid, and a fresh start then works normally.
